// File: rtl/stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// stream_rr_arbiter
//
// Packet-aware round-robin arbiter that merges n valid/ready streams into a
// single registered output stream. Once a requester wins with a non-final
// beat it owns the output until its end-of-packet beat is accepted, so
// packets are never interleaved. After a packet ends, the search for the
// next winner starts at the requester after the one that just finished.
//
// Parameters
//   w         data width per requester
//   n         number of requesters (2..8)
//   iw        width of the requester index (derived)
//
// Ports
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   up_vld    per-requester valid (bit i = requester i)
//   up_rdy    per-requester ready, one-hot or zero
//   up_data   requester i data at [i*w +: w]
//   up_last   per-requester end-of-packet marker
//   down_vld  registered output valid
//   down_rdy  downstream ready
//   down_data registered output data
//   down_last registered end-of-packet marker
//   down_src  index of the requester that produced the held beat
// ---------------------------------------------------------------------------
module stream_rr_arbiter #(
    parameter int w = 8,
    parameter int n = 4,
    localparam int iw = ($clog2(n) > 1) ? $clog2(n) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [n-1:0]   up_vld,
    output logic [n-1:0]   up_rdy,
    input  logic [n*w-1:0] up_data,
    input  logic [n-1:0]   up_last,
    output logic           down_vld,
    input  logic           down_rdy,
    output logic [w-1:0]   down_data,
    output logic           down_last,
    output logic [iw-1:0]  down_src
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t        state_reg, state_next;
    logic [iw-1:0] ptr_reg, ptr_next;
    logic [iw-1:0] owner_reg, owner_next;

    logic          down_vld_reg;
    logic [w-1:0]  down_data_reg;
    logic          down_last_reg;
    logic [iw-1:0] down_src_reg;

    logic          out_free;
    logic [2*n-1:0] vld_dbl;
    logic [n-1:0]   vld_rot;
    logic [n-1:0]   rot_oh;
    logic [2*n-1:0] win_dbl;
    logic [n-1:0]   win_oh;
    logic [n-1:0]   owner_oh;
    logic [n-1:0]   gnt_oh;
    logic [n-1:0]   acc_oh;
    logic           accept;

    // AND-OR mux chains over the accepted one-hot vector
    logic [w-1:0]  data_chain  [n+1];
    logic          last_chain  [n+1];
    logic [iw-1:0] src_chain   [n+1];

    logic [w-1:0]  acc_data;
    logic          acc_last;
    logic [iw-1:0] acc_src;

    assign out_free = ~down_vld_reg | down_rdy;

    // Round-robin search: rotate the requests so ptr sits at bit 0, isolate
    // the lowest set bit, then rotate back. The doubled vectors make the
    // rotation wrap correctly for any n, power of two or not.
    assign vld_dbl = {up_vld, up_vld} >> ptr_reg;
    assign vld_rot = vld_dbl[n-1:0];
    assign rot_oh  = vld_rot & (~vld_rot + {{(n-1){1'b0}}, 1'b1});
    assign win_dbl = {rot_oh, rot_oh} << ptr_reg;
    assign win_oh  = win_dbl[2*n-1:n];

    genvar gi;
    generate
        for (gi = 0; gi < n; gi++) begin : g_owner
            assign owner_oh[gi] = (owner_reg == iw'(gi));
        end
    endgenerate

    // In LOCKED the owner is offered the slot whether or not it is valid,
    // which is what keeps everyone else out while the owner stalls.
    always_comb begin
        gnt_oh = '0;
        if (!rst && out_free) begin
            if (state_reg == LOCKED) begin
                gnt_oh = owner_oh;
            end else begin
                gnt_oh = win_oh;
            end
        end
    end

    assign up_rdy = gnt_oh;
    assign acc_oh = gnt_oh & up_vld;
    assign accept = |acc_oh;

    assign data_chain[0] = '0;
    assign last_chain[0] = 1'b0;
    assign src_chain[0]  = '0;
    generate
        for (gi = 0; gi < n; gi++) begin : g_mux
            assign data_chain[gi+1] = data_chain[gi] | (acc_oh[gi] ? up_data[gi*w +: w] : '0);
            assign last_chain[gi+1] = last_chain[gi] | (acc_oh[gi] & up_last[gi]);
            assign src_chain[gi+1]  = src_chain[gi]  | (acc_oh[gi] ? iw'(gi) : '0);
        end
    endgenerate

    assign acc_data = data_chain[n];
    assign acc_last = last_chain[n];
    assign acc_src  = src_chain[n];

    function automatic logic [iw-1:0] next_idx(input logic [iw-1:0] idx);
        if (idx == iw'(n - 1)) begin
            return '0;
        end
        return idx + {{(iw-1){1'b0}}, 1'b1};
    endfunction

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        owner_next = owner_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (acc_last) begin
                        ptr_next = next_idx(acc_src);
                    end else begin
                        state_next = LOCKED;
                        owner_next = acc_src;
                    end
                end
            end
            LOCKED: begin
                if (accept && acc_last) begin
                    state_next = IDLE;
                    ptr_next   = next_idx(owner_reg);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            owner_reg     <= '0;
            down_vld_reg  <= 1'b0;
            down_data_reg <= '0;
            down_last_reg <= 1'b0;
            down_src_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
            if (accept) begin
                // A new beat may replace one leaving in the same cycle
                down_vld_reg  <= 1'b1;
                down_data_reg <= acc_data;
                down_last_reg <= acc_last;
                down_src_reg  <= acc_src;
            end else if (down_rdy) begin
                down_vld_reg <= 1'b0;
            end
        end
    end

    assign down_vld  = down_vld_reg;
    assign down_data = down_data_reg;
    assign down_last = down_last_reg;
    assign down_src  = down_src_reg;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_rr_arbiter
//
// Drives two arbiter instances (n=4 and n=3, w=8) and compares every cycle
// against a transaction-level reference: owner/pointer bookkeeping taken
// straight from the arbitration rules, plus a one-entry output holding
// register. Directed scenarios come first, then randomized traffic with
// occasional resets.
// ---------------------------------------------------------------------------
module tb_stream_rr_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // instance A: n = 4
    logic [3:0]  vld_a, last_a, rdy_a;
    logic [31:0] data_a;
    logic        drdy_a, dvld_a, dlast_a;
    logic [7:0]  ddata_a;
    logic [1:0]  dsrc_a;

    // instance B: n = 3
    logic [2:0]  vld_b, last_b, rdy_b;
    logic [23:0] data_b;
    logic        drdy_b, dvld_b, dlast_b;
    logic [7:0]  ddata_b;
    logic [1:0]  dsrc_b;

    stream_rr_arbiter #(.w(8), .n(4)) dut_a (
        .clk(clk), .rst(rst),
        .up_vld(vld_a), .up_rdy(rdy_a), .up_data(data_a), .up_last(last_a),
        .down_vld(dvld_a), .down_rdy(drdy_a), .down_data(ddata_a),
        .down_last(dlast_a), .down_src(dsrc_a)
    );

    stream_rr_arbiter #(.w(8), .n(3)) dut_b (
        .clk(clk), .rst(rst),
        .up_vld(vld_b), .up_rdy(rdy_b), .up_data(data_b), .up_last(last_b),
        .down_vld(dvld_b), .down_rdy(drdy_b), .down_data(ddata_b),
        .down_last(dlast_b), .down_src(dsrc_b)
    );

    int checks   = 0;
    int failures = 0;

    // reference state per instance: owner -1 means no packet in progress
    int         m_ptr   [2];
    int         m_owner [2];
    logic       m_dvld  [2];
    logic [7:0] m_ddata [2];
    logic       m_dlast [2];
    int         m_dsrc  [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_ptr[d]   = 0;
            m_owner[d] = -1;
            m_dvld[d]  = 1'b0;
            m_ddata[d] = '0;
            m_dlast[d] = 1'b0;
            m_dsrc[d]  = 0;
        end
    endtask

    task automatic model_step(input int d);
        int          nn;
        int          g;
        logic [3:0]  v, l, o_rdy, e_rdy;
        logic [31:0] dt;
        logic        dr, free, acc;
        logic        o_vld, o_last;
        logic [7:0]  o_data;
        logic [1:0]  o_src;
        string       pfx;
        if (d == 0) begin
            nn = 4; v = vld_a; l = last_a; dt = data_a; dr = drdy_a;
            o_rdy = rdy_a; o_vld = dvld_a; o_data = ddata_a; o_last = dlast_a; o_src = dsrc_a;
            pfx = "n4";
        end else begin
            nn = 3; v = {1'b0, vld_b}; l = {1'b0, last_b}; dt = {8'h00, data_b}; dr = drdy_b;
            o_rdy = {1'b0, rdy_b}; o_vld = dvld_b; o_data = ddata_b; o_last = dlast_b; o_src = dsrc_b;
            pfx = "n3";
        end

        free = !m_dvld[d] || dr;
        g = -1;
        if (!rst && free) begin
            if (m_owner[d] >= 0) begin
                g = m_owner[d];
            end else begin
                for (int k = 0; k < nn; k++) begin
                    int idx;
                    idx = (m_ptr[d] + k) % nn;
                    if (g < 0 && v[idx]) g = idx;
                end
            end
        end
        e_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;

        check({pfx, "_up_rdy"}, 32'(o_rdy), 32'(e_rdy));
        check({pfx, "_down_vld"}, 32'(o_vld), 32'(m_dvld[d]));
        if (m_dvld[d] || rst) begin
            check({pfx, "_down_data"}, 32'(o_data), 32'(m_ddata[d]));
            check({pfx, "_down_last"}, 32'(o_last), 32'(m_dlast[d]));
            check({pfx, "_down_src"},  32'(o_src),  32'(m_dsrc[d]));
        end

        acc = (g >= 0) && v[g];
        if (acc) begin
            $display("  %s accept src=%0d data=%02h last=%0b", pfx, g, 8'(dt >> (8 * g)), l[g]);
        end

        if (rst) begin
            m_ptr[d]   = 0;
            m_owner[d] = -1;
            m_dvld[d]  = 1'b0;
            m_ddata[d] = '0;
            m_dlast[d] = 1'b0;
            m_dsrc[d]  = 0;
        end else begin
            if (acc) begin
                m_dvld[d]  = 1'b1;
                m_ddata[d] = 8'(dt >> (8 * g));
                m_dlast[d] = l[g];
                m_dsrc[d]  = g;
                if (l[g]) begin
                    m_owner[d] = -1;
                    m_ptr[d]   = (g + 1) % nn;
                end else begin
                    m_owner[d] = g;
                end
            end else if (dr) begin
                m_dvld[d] = 1'b0;
            end
        end
    endtask

    // inputs are set just after a rising edge; checks run mid-cycle
    task automatic cycle();
        #3;
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        vld_a = '0; last_a = '0; drdy_a = 1'b1;
        vld_b = '0; last_b = '0; drdy_b = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        data_a = '0;
        data_b = '0;
        @(posedge clk);
        #1;
        model_reset();
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // all requesters, single-beat packets: strict rotation
        vld_a = 4'hf; last_a = 4'hf; drdy_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            data_a = $urandom;
            cycle();
        end

        // requester 1 sends a 3-beat packet while 0 and 2 wait
        vld_a = 4'b0010; last_a = 4'b0000; data_a = $urandom;
        cycle();
        vld_a = 4'b0111; last_a = 4'b0101; data_a = $urandom;
        cycle();
        last_a = 4'b0111; data_a = $urandom;
        cycle();
        for (int i = 0; i < 3; i++) begin
            data_a = $urandom;
            cycle();
        end

        // downstream stall with a held beat, then release
        vld_a = 4'hf; last_a = 4'hf; data_a = $urandom;
        cycle();
        drdy_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_a = $urandom;
            cycle();
        end
        drdy_a = 1'b1;
        cycle();
        cycle();
        idle_all();
        cycle();

        // owner 3 locks, then stalls while requester 0 asks
        vld_a = 4'b1000; last_a = 4'b0000; data_a = $urandom;
        for (int i = 0; i < 4; i++) cycle();
        vld_a = 4'b1000;
        cycle();
        vld_a = 4'b0001; last_a = 4'b0001;
        for (int i = 0; i < 4; i++) cycle();
        vld_a = 4'b1001; last_a = 4'b1001; data_a = $urandom;
        cycle();
        cycle();
        idle_all();
        cycle();

        // n = 3: requester 2 alone, then requester 0 after the wrap
        vld_b = 3'b100; last_b = 3'b111;
        for (int i = 0; i < 3; i++) begin
            data_b = 24'($urandom);
            cycle();
        end
        vld_b = 3'b001;
        data_b = 24'($urandom);
        cycle();
        cycle();
        idle_all();
        cycle();

        // reset mid-packet with a stalled held beat
        vld_a = 4'b0100; last_a = 4'b0000; drdy_a = 1'b0; data_a = $urandom;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        vld_a = 4'hf; last_a = 4'hf; drdy_a = 1'b1; data_a = $urandom;
        cycle();
        cycle();
        idle_all();
        cycle();

        // randomized traffic on both instances
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 149) == 0);
            vld_a  = 4'($urandom);
            last_a = 4'($urandom | $urandom);
            data_a = $urandom;
            drdy_a = ($urandom_range(0, 3) != 0);
            vld_b  = 3'($urandom);
            last_b = 3'($urandom | $urandom);
            data_b = 24'($urandom);
            drdy_b = ($urandom_range(0, 3) != 0);
            cycle();
        end
        rst = 1'b0;
        idle_all();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
